// File: rtl/bk8_multiword_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bk8_multiword_sequencer
// Multi-precision add/subtract: one 8-bit Brent-Kung adder reused per byte, LSB first.
// Rev 1.0
// ---------------------------------------------------------------------------
module bk8_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*WORDS-1:0]   in_a,
  input  logic [8*WORDS-1:0]   in_b,
  input  logic                 in_sub,
  input  logic                 in_cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*WORDS-1:0]   out_sum,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int W    = 8 * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WORDS-1:0][7:0]   a_q, a_d;
  logic [WORDS-1:0][7:0]   b_q, b_d;
  logic                    sub_q, sub_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic [WORDS-1:0][7:0]   acc_q, acc_d;
  logic [W-1:0]            sum_q, sum_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;

  logic [7:0] x1, x2, g, p, c, s;
  logic       cin, cout;
  logic       g0, g10, g32, p32, g54, p54, g76, p76, g74, p74;
  logic       gg2, gg3, gg4, gg5, gg6, gg7;

  // Brent-Kung prefix tree; group terms "ggN" span bit N down to the carry-in.
  always_comb begin
    x1  = a_q[idx_q];
    x2  = b_q[idx_q] ^ {8{sub_q}};
    cin = carry_q;
    g   = x1 & x2;
    p   = x1 ^ x2;
    g0  = g[0] | (p[0] & cin);
    g10 = g[1] | (p[1] & g0);
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    g54 = g[5] | (p[5] & g[4]);
    p54 = p[5] & p[4];
    g76 = g[7] | (p[7] & g[6]);
    p76 = p[7] & p[6];
    gg3 = g32 | (p32 & g10);
    g74 = g76 | (p76 & g54);
    p74 = p76 & p54;
    gg7 = g74 | (p74 & gg3);
    gg5 = g54 | (p54 & gg3);
    gg2 = g[2] | (p[2] & g10);
    gg4 = g[4] | (p[4] & gg3);
    gg6 = g[6] | (p[6] & gg5);
    c    = {gg6, gg5, gg4, gg3, gg2, g10, g0, cin};
    s    = p ^ c;
    cout = gg7;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          idx_d   = '0;
          carry_d = in_sub ? ~in_cin : in_cin;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d[idx_q] = s;
        carry_d      = cout;
        if (idx_q == IDXW'(WORDS - 1)) begin
          sum_d   = acc_d;
          cout_d  = cout;
          // carry out of the MSB vs carry into it
          ovf_d   = cout ^ (x1[7] ^ x2[7] ^ s[7]);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bk8_multiword_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bk8_multiword_sequencer
// Directed + random checks of the sequencer (WORDS=4 and WORDS=1 builds).
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bk8_multiword_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_sub, in_cin, out_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_ready, out_valid, out_cout, out_ovf, busy;
  logic [W-1:0] out_sum;

  logic         in_valid1, in_sub1, in_cin1, out_ready1;
  logic [7:0]   in_a1, in_b1;
  logic         in_ready1, out_valid1, out_cout1, out_ovf1, busy1;
  logic [7:0]   out_sum1;

  int errors = 0;
  int checks = 0;

  bk8_multiword_sequencer #(.WORDS(WORDS)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  bk8_multiword_sequencer #(.WORDS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_sub(in_sub1), .in_cin(in_cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1), .out_ovf(out_ovf1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Integer-arithmetic reference on an n-bit datapath.
  function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                input logic s, input logic c, input int n,
                                output logic [63:0] sum, output logic co, output logic ov);
    logic [63:0] mask, full;
    mask = (64'd1 << n) - 64'd1;
    full = s ? (a - b - 64'(c)) : (a + b + 64'(c));
    sum  = full & mask;
    co   = s ? ~full[n] : full[n];
    if (s) ov = (a[n-1] != b[n-1]) && (sum[n-1] != a[n-1]);
    else   ov = (a[n-1] == b[n-1]) && (sum[n-1] != a[n-1]);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input int hold);
    logic [63:0] es;
    logic        eco, eov;
    model(64'(a), 64'(b), s, c, W, es, eco, eov);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = s; in_cin = c;
    step();
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom); in_cin = 1'($urandom);
    for (int k = 0; k < WORDS; k++) begin
      chk("busy_run", busy, 1);
      chk("out_valid_run", out_valid, 0);
      step();
    end
    chk("out_valid_done", out_valid, 1);
    chk("busy_done", busy, 0);
    chk("out_sum", out_sum, es);
    chk("out_cout", out_cout, eco);
    chk("out_ovf", out_ovf, eov);
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sum", out_sum, es);
      chk("hold_flags", {out_cout, out_ovf}, {eco, eov});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_sum_kept", out_sum, es);
    in_valid = 1'b0;
  endtask

  task automatic run_op1(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
    logic [63:0] es;
    logic        eco, eov;
    model(64'(a), 64'(b), s, c, 8, es, eco, eov);
    chk("w1_in_ready", in_ready1, 1);
    in_valid1 = 1'b1; in_a1 = a; in_b1 = b; in_sub1 = s; in_cin1 = c;
    step();
    in_valid1 = 1'b0; in_a1 = 8'($urandom); in_b1 = 8'($urandom);
    chk("w1_busy", busy1, 1);
    chk("w1_valid_run", out_valid1, 0);
    step();
    chk("w1_valid_done", out_valid1, 1);
    chk("w1_sum", out_sum1, es);
    chk("w1_flags", {out_cout1, out_ovf1}, {eco, eov});
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk("w1_post_valid", out_valid1, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_sub1 = 1'b0; in_cin1 = 1'b0; out_ready1 = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_flags", {out_cout, out_ovf}, 2'b00);
    chk("rst_w1_in_ready", in_ready1, 1);
    rst = 1'b0;
    step();

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 10);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op(32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 1);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 2);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 0);
    run_op(32'h0000_0009, 32'h0000_0003, 1'b1, 1'b1, 3);

    // abort while byte 2 is in flight
    in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h1357_9BDF; in_sub = 1'b0; in_cin = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy_low", busy, 0);
    chk("abort_sum", out_sum, 0);
    chk("abort_flags", {out_cout, out_ovf}, 2'b00);
    run_op(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0, 0);

    for (int i = 0; i < 10; i++)
      run_op($urandom, $urandom, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    run_op1(8'h80, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op1(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bk8_multiword_sequencer.md
Name: bk8_multiword_sequencer

Overview:
- Multi-precision add/subtract controller that time-multiplexes a single bk8 8-bit prefix adder across WORDS byte lanes, least-significant byte first.
- The carry is held in a register between bytes.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Produces a WORDS*8-bit sum, carry-out and signed-overflow flag.

Parameters:
- WORDS, 4, number of 8-bit bytes per operand (legal range 1..16); operand width W = 8*WORDS.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has an operation
- in_ready  output  1  block can accept an operation
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_sub  input  1  0 = A+B+cin, 1 = A-B-cin
- in_cin  input  1  carry-in (add) / borrow-in (sub)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  W  result
- out_cout  output  1  final carry (sub: 1 = no borrow)
- out_ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN

Behaviour:
- Reset values: state IDLE; in_ready=1; out_valid=0; out_sum=0; out_cout=0; out_ovf=0; busy=0. All internal registers (operands, byte index, carry, accumulator) are cleared.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state==RUN).
- IDLE:
  - On in_valid&&in_ready: latch in_a, in_b, in_sub.
  - Set idx=0.
  - Set the carry register to in_sub ? ~in_cin : in_cin.
  - Go to RUN.
- RUN, each cycle, processes byte idx:
  - Adder inputs: x1 = A[8*idx+7:8*idx], x2 = B byte XOR {8{sub}}, cin = carry register.
  - On the edge: the adder's s is written into accumulator byte idx, and carry <= adder cout.
  - If idx==WORDS-1, go to DONE; otherwise idx <= idx+1.
- Final-byte flags:
  - out_cout <= cout of the last byte.
  - out_ovf <= cout XOR (x1[7] XOR x2[7] XOR s[7]), i.e. carry-out XOR carry into bit W-1, using the inverted x2 when subtracting.
  - out_sum <= full accumulator including the last byte.
  - All three are written on the RUN->DONE edge.
- Latency:
  - Accept at edge T -> out_valid high in the cycle following edge T+WORDS.
  - WORDS=1 gives one RUN cycle.
- DONE:
  - Hold out_sum/out_cout/out_ovf stable while out_ready=0.
  - On out_ready=1, return to IDLE; out_valid drops next cycle.
  - in_ready rises in the cycle after the output handshake. Minimum accept-to-accept spacing is WORDS+2 cycles.
- Result registers keep their last values after leaving DONE. They change only on the next RUN->DONE edge or on reset.
- in_a/in_b/in_sub/in_cin changes after acceptance have no effect. in_valid while not in IDLE is ignored; the producer must hold the operation until in_ready.
- out_ready while not in DONE is ignored.
- Reset mid-RUN or in DONE:
  - Abort the operation; no result is delivered.
  - All outputs return to reset values on the next edge.
  - The aborted operation is never reissued.
- rst has priority over every handshake in the same cycle.
- Arithmetic is modulo 2^W. For subtraction, out_cout = NOT borrow-out.

Test Plan:
- WORDS=4, A=0xFFFFFFFF, B=0x00000001, add, cin=0 -> out_sum=0x00000000, out_cout=1, out_ovf=0. out_valid rises exactly 4 cycles after the accept edge (counting per Latency rule); busy high for 4 cycles.
- A=0x7FFFFFFF, B=0x00000001, add -> out_sum=0x80000000, out_cout=0, out_ovf=1. Repeat with A=0x000000FF, B=0, cin=1 -> out_sum=0x00000100, carry rippling across the byte boundary.
- Subtract: A=5, B=7, cin=0 -> out_sum=0xFFFFFFFE, out_cout=0, out_ovf=0. Then A=0x80000000, B=1 -> out_sum=0x7FFFFFFF, out_cout=1, out_ovf=1. Then A=9, B=3, borrow-in=1 -> 5, out_cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0; a new in_valid is not accepted until the cycle after out_ready=1.
- Reset mid-RUN: assert rst during byte index 2 -> next cycle state IDLE, in_ready=1, out_valid=0, out_sum=0. A following operation 0x01020304+0x10203040 yields 0x11223344 with no residue from the aborted operation.
- WORDS=1 build: A=0x80, B=0x80, add -> out_sum=0x00, out_cout=1, out_ovf=1, out_valid 1 cycle after the accept edge's RUN cycle.
